// File: rtl/picorv_uart_tx_if.sv
// ---------------------------------------------------------------------------
// picorv_uart_tx_if
//
// picorv32 native memory bus as seen by one slave on the shared mem_* bus.
//
// Signals:
//   mem_valid  request valid, held by the CPU until mem_ready
//   mem_instr  instruction fetch flag
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_wstrb  byte strobes, all-zero means read
//   mem_ready  one-cycle acknowledge from the slave
//   mem_rdata  read data, valid while mem_ready is high
//   hit        slave address decode, used by the top-level bus mux
//
// Modports:
//   master  CPU side (drives the request, receives ack/data/hit)
//   slave   peripheral side (receives the request, drives ack/data/hit)
// ---------------------------------------------------------------------------
interface picorv_uart_tx_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        hit;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, hit
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, hit
    );
endinterface

// File: rtl/picorv_uart_tx.sv
// ---------------------------------------------------------------------------
// picorv_uart_tx
//
// Memory-mapped console transmitter for the picorv32 native bus. Bytes
// written to the DATA register are queued in a small FIFO and sent on
// uart_tx as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
//
// Register map:
//   BASE_ADDR      DATA    write: queue wdata[7:0] (needs wstrb[0]); read: 0
//   BASE_ADDR + 4  STATUS  read: {16'b0, level[7:0], 6'b0, tx_busy, full}
//
// Parameters:
//   BASE_ADDR  address of the DATA register
//   CLK_DIV    clock cycles per UART bit (2..65535)
//   FIFO_AW    FIFO address width, depth = 2**FIFO_AW
//
// Ports:
//   clk      system clock, rising edge
//   resetn   synchronous active-low reset
//   bus      picorv_uart_tx_if.slave (mem_* request, mem_ready/mem_rdata, hit)
//   uart_tx  serial output, idle high
//   tx_busy  FIFO non-empty or frame in progress (registered, aligned to line)
//
// Optional feature:
//   `define UART_TX_PARITY_EN inserts an even-parity bit between the data
//   bits and the stop bit (frame = 11 bit times).
// ---------------------------------------------------------------------------
module picorv_uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned CLK_DIV   = 868,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    picorv_uart_tx_if.slave   bus,
    output logic              uart_tx,
    output logic              tx_busy
);

    localparam int unsigned         DEPTH       = 2 ** FIFO_AW;
    localparam logic [31:0]         DATA_ADDR   = BASE_ADDR;
    localparam logic [31:0]         STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0]         BAUD_LAST   = 16'(CLK_DIV - 1);
    localparam logic [FIFO_AW-1:0]  PTR_ONE     = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]    LVL_ONE     = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]    LVL_FULL    = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    tx_state_t          state;
    logic [15:0]        baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift_reg;
`ifdef UART_TX_PARITY_EN
    logic               parity_bit;
`endif

    logic [7:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;

    // -----------------------------------------------------------------------
    // Combinational decode and control
    // -----------------------------------------------------------------------
    logic        is_data;
    logic        is_status;
    logic        push_req;
    logic        accept;
    logic        push;
    logic        pop;
    logic        status_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        baud_last;
    logic        line_bit;
    logic [31:0] status_word;

    // Only the low byte of the write data carries a character.
    logic unused_wdata;
    assign unused_wdata = ^bus.mem_wdata[31:8];

    // Exact 32-bit compares also enforce mem_addr[1:0] == 0, since both
    // register addresses are word aligned.
    assign is_data   = (bus.mem_addr == DATA_ADDR);
    assign is_status = (bus.mem_addr == STATUS_ADDR);
    assign bus.hit   = bus.mem_valid && (is_data || is_status);

    assign fifo_full  = (level == LVL_FULL);
    assign fifo_empty = (level == '0);
    assign baud_last  = (baud_cnt == BAUD_LAST);

    assign status_word = {16'b0, 8'(level), 6'b0, tx_busy, fifo_full};

    // NOTE: every signal assigned in an always_comb gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        push_req  = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        status_rd = 1'b0;
        pop       = 1'b0;

        // mem_ready high means the CPU is still holding last cycle's request;
        // it must not be acknowledged a second time.
        if (bus.hit && !bus.mem_ready) begin
            push_req  = !bus.mem_instr && is_data && bus.mem_wstrb[0];
            // A push into a full FIFO is withheld (CPU stalls), even if a pop
            // frees a slot this same cycle; it is accepted next cycle.
            accept    = !(push_req && fifo_full);
            push      = push_req && !fifo_full;
            status_rd = !bus.mem_instr && is_status && (bus.mem_wstrb == 4'b0000);
        end

        if (!fifo_empty) begin
            pop = (state == ST_IDLE) || (state == ST_STOP && baud_last);
        end
    end

    always_comb begin
        line_bit = 1'b1;
        case (state)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_bit = parity_bit;
`endif
            default:   line_bit = 1'b1;
        endcase
    end

    // -----------------------------------------------------------------------
    // Bus acknowledge
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            bus.mem_ready <= accept;
            bus.mem_rdata <= status_rd ? status_word : '0;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers and level, so resetting the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Transmit state machine
    // -----------------------------------------------------------------------
    // uart_tx and tx_busy are registered from the current state, so the line
    // lags the state by one cycle. This puts the start bit two cycles after
    // the ack cycle and drops tx_busy exactly as the stop bit ends.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            uart_tx    <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            uart_tx <= line_bit;
            tx_busy <= (state != ST_IDLE) || !fifo_empty;

            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg  <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_mem[rd_ptr];
`endif
                        bit_cnt    <= '0;
                        state      <= ST_START;
                    end
                end

                ST_START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif

                ST_STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        // Back-to-back frames: next start bit follows the stop
                        // bit with no idle gap.
                        if (pop) begin
                            shift_reg  <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^fifo_mem[rd_ptr];
`endif
                            bit_cnt    <= '0;
                            state      <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_picorv_uart_tx
//
// Bench for picorv_uart_tx with CLK_DIV=4, FIFO_AW=2. Bus stimulus pushes the
// expected read data of every access into exp_rd and every character that
// should reach the line into exp_ch; two monitors (bus ack, UART line) pop
// and compare independently of the stimulus.
// ---------------------------------------------------------------------------
module tb_picorv_uart_tx;

    localparam int          CLK_DIV  = 4;
    localparam int          FIFO_AW  = 2;
    localparam logic [31:0] DATA_A   = 32'h1000_0000;
    localparam logic [31:0] STATUS_A = 32'h1000_0004;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS    = 11;
`else
    localparam int          NBITS    = 10;
`endif
    localparam int          FRAME    = NBITS * CLK_DIV;

    logic clk;
    logic resetn;
    logic uart_tx;
    logic tx_busy;

    picorv_uart_tx_if bus_if ();

    picorv_uart_tx #(
        .BASE_ADDR (DATA_A),
        .CLK_DIV   (CLK_DIV),
        .FIFO_AW   (FIFO_AW)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .bus     (bus_if.slave),
        .uart_tx (uart_tx),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_rd[$];
    logic [7:0]  exp_ch[$];
    int          frame_starts[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Bus ack monitor: every mem_ready must be a single-cycle pulse that
    // matches an issued request, carrying the expected read data.
    // ------------------------------------------------------------------
    initial begin : ready_mon
        logic        prev_rdy;
        logic [31:0] e;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.mem_ready === 1'b1) begin
                check("ready_pulse", {31'b0, prev_rdy}, 32'd0);
                check("ready_expected", {31'b0, (exp_rd.size() > 0)}, 32'd1);
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    check("rdata", bus_if.mem_rdata, e);
                end
            end
            prev_rdy = bus_if.mem_ready;
        end
    end

    // ------------------------------------------------------------------
    // UART line monitor: compares every cycle of each frame against the
    // ideal waveform of the expected character and decodes it mid-bit.
    // ------------------------------------------------------------------
    initial begin : uart_mon
        logic        prev_tx;
        logic [10:0] bits;
        logic [10:0] samp;
        logic [7:0]  ch;
        bit          have_exp;
        bit          aborted;
        int          bad;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (resetn && prev_tx && !uart_tx) begin
                frame_starts.push_back(cyc);
                have_exp = (exp_ch.size() > 0);
                check("frame_expected", {31'b0, have_exp}, 32'd1);
                ch = 8'h00;
                if (have_exp) ch = exp_ch.pop_front();
                bits      = '1;
                bits[0]   = 1'b0;
                bits[8:1] = ch;
`ifdef UART_TX_PARITY_EN
                bits[9]   = ^ch;
`endif
                samp    = '1;
                bad     = 0;
                aborted = 1'b0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!resetn) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (uart_tx !== bits[c / CLK_DIV]) bad++;
                    if ((c % CLK_DIV) == (CLK_DIV / 2)) samp[c / CLK_DIV] = uart_tx;
                end
                if (!aborted && have_exp) begin
                    check("frame_char", {24'b0, samp[8:1]}, {24'b0, ch});
                    check("frame_shape", bad, 0);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", {31'b0, samp[9]}, {31'b0, ^ch});
`endif
                end
            end
            prev_tx = uart_tx;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input logic instr,
                              input logic [31:0] exp_rdata, output int ack_cyc);
        int n;
        exp_rd.push_back(exp_rdata);
        @(posedge clk);
        #1;
        bus_if.mem_valid = 1'b1;
        bus_if.mem_instr = instr;
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = wdata;
        bus_if.mem_wstrb = wstrb;
        n       = 0;
        ack_cyc = -1;
        @(negedge clk);
        check("hit", {31'b0, bus_if.hit}, 32'd1);
        while (bus_if.mem_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus_if.mem_ready !== 1'b1) begin
            check("ack_timeout", {31'b0, bus_if.mem_ready}, 32'd1);
            void'(exp_rd.pop_back());
        end else begin
            ack_cyc = cyc;
        end
        // Hold the request through the ack edge, as the CPU does.
        @(posedge clk);
        #1;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_instr = 1'b0;
        bus_if.mem_wstrb = 4'b0000;
    endtask

    task automatic wr_char(input logic [7:0] ch, input bit sent, output int ack_cyc);
        if (sent) exp_ch.push_back(ch);
        bus_access(DATA_A, {24'b0, ch}, 4'b0001, 1'b0, 32'd0, ack_cyc);
    endtask

    task automatic probe_no_ack(input logic [31:0] addr);
        int readies;
        @(posedge clk);
        #1;
        bus_if.mem_valid = 1'b1;
        bus_if.mem_instr = 1'b0;
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = 32'h0000_005A;
        bus_if.mem_wstrb = 4'b0001;
        readies = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("no_hit", {31'b0, bus_if.hit}, 32'd0);
            if (bus_if.mem_ready === 1'b1) readies++;
        end
        check("no_ack", readies, 0);
        @(posedge clk);
        #1;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_wstrb = 4'b0000;
    endtask

    task automatic wait_idle(output int drop_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy !== 1'b0) check("idle_timeout", {31'b0, tx_busy}, 32'd0);
        drop_cyc = cyc;
    endtask

    task automatic wait_starts(input int want);
        int n;
        n = 0;
        while (frame_starts.size() < want && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (frame_starts.size() < want) check("start_timeout", frame_starts.size(), want);
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin : main
        int a0, a1, a5, drop, dummy;

        resetn           = 1'b0;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_instr = 1'b0;
        bus_if.mem_addr  = '0;
        bus_if.mem_wdata = '0;
        bus_if.mem_wstrb = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_mem_ready", {31'b0, bus_if.mem_ready}, 32'd0);
        check("rst_mem_rdata", bus_if.mem_rdata, 32'd0);
        check("rst_tx_busy", {31'b0, tx_busy}, 32'd0);
        resetn = 1'b1;
        bus_access(STATUS_A, 32'd0, 4'b0000, 1'b0, 32'h0000_0000, dummy);

        // Single write 'A': start bit two cycles after the ack cycle,
        // tx_busy drops as the stop bit ends.
        frame_starts.delete();
        wr_char(8'h41, 1'b1, a0);
        wait_starts(1);
        if (frame_starts.size() > 0) check("start_latency", frame_starts[0], a0 + 2);
        wait_idle(drop);
        if (frame_starts.size() > 0) check("busy_drop_single", drop, frame_starts[0] + FRAME);

        // Back-to-back 'H','i': no idle gap, two frame times total.
        frame_starts.delete();
        wr_char(8'h48, 1'b1, a0);
        wr_char(8'h69, 1'b1, a1);
        wait_starts(2);
        if (frame_starts.size() > 1) check("b2b_gap", frame_starts[1] - frame_starts[0], FRAME);
        wait_idle(drop);
        if (frame_starts.size() > 0) check("busy_drop_b2b", drop, frame_starts[0] + 2 * FRAME);

        // Full stall: one char on the line, four fill the FIFO, the fifth
        // is acked only after the first pop (its ack coincides with the
        // second start bit on the line).
        frame_starts.delete();
        wr_char(8'h30, 1'b1, a0);
        wr_char(8'h31, 1'b1, dummy);
        wr_char(8'h32, 1'b1, dummy);
        wr_char(8'h33, 1'b1, dummy);
        wr_char(8'h34, 1'b1, dummy);
        bus_access(STATUS_A, 32'd0, 4'b0000, 1'b0, 32'h0000_0403, dummy);
        wr_char(8'h35, 1'b1, a5);
        wait_starts(2);
        if (frame_starts.size() > 1) check("stall_ack", a5, frame_starts[1]);
        wait_idle(drop);
        check("stall_all_sent", exp_ch.size(), 0);
        check("stall_frames", frame_starts.size(), 6);

        // STATUS with three queued behind an active frame; instruction
        // fetch hits are acked with zero data.
        wr_char(8'h61, 1'b1, dummy);
        wr_char(8'h62, 1'b1, dummy);
        wr_char(8'h63, 1'b1, dummy);
        wr_char(8'h64, 1'b1, dummy);
        bus_access(STATUS_A, 32'd0, 4'b0000, 1'b0, 32'h0000_0302, dummy);
        bus_access(STATUS_A, 32'd0, 4'b0000, 1'b1, 32'h0000_0000, dummy);
        wait_idle(drop);
        check("status_all_sent", exp_ch.size(), 0);

        // Decode and strobes.
        frame_starts.delete();
        probe_no_ack(32'h1000_0008);
        probe_no_ack(32'h1000_0002);
        bus_access(DATA_A, 32'h0000_0077, 4'b0010, 1'b0, 32'd0, dummy);
        bus_access(DATA_A, 32'd0, 4'b0000, 1'b0, 32'd0, dummy);
        bus_access(STATUS_A, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'd0, dummy);
        repeat (60) @(negedge clk);
        check("no_frame_sent", frame_starts.size(), 0);
        check("idle_after_discard", {31'b0, tx_busy}, 32'd0);
        bus_access(STATUS_A, 32'd0, 4'b0000, 1'b0, 32'h0000_0000, dummy);

        // 'A' (parity 0) and 'C' (parity 1).
        wr_char(8'h41, 1'b1, dummy);
        wr_char(8'h43, 1'b1, dummy);
        wait_idle(drop);
        check("parity_pair_sent", exp_ch.size(), 0);

        // Reset mid-frame: line returns high on the first reset edge and the
        // queued characters are discarded.
        frame_starts.delete();
        wr_char(8'h00, 1'b1, dummy);
        wr_char(8'h55, 1'b1, dummy);
        wr_char(8'h66, 1'b1, dummy);
        wait_starts(1);
        repeat (10) @(negedge clk);
        check("pre_reset_low", {31'b0, uart_tx}, 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("reset_mem_ready", {31'b0, bus_if.mem_ready}, 32'd0);
        check("reset_tx_busy", {31'b0, tx_busy}, 32'd0);
        repeat (4) @(negedge clk);
        exp_ch.delete();
        resetn = 1'b1;
        bus_access(STATUS_A, 32'd0, 4'b0000, 1'b0, 32'h0000_0000, dummy);
        repeat (50) @(negedge clk);
        check("reset_frames", frame_starts.size(), 1);
        check("reset_line_idle", {31'b0, uart_tx}, 32'd1);
        check("rd_queue_drained", exp_rd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/picorv_uart_tx.md
Name: picorv_uart_tx

Overview:
- Memory-mapped console transmitter that responds to picorv32 native-bus writes at the console address.
- Buffers each character in a FIFO and serialises it onto a UART TX line as 8N1 framing.
- Synthesizable replacement for simulation-only console printing; sits beside picorv_mem on the shared mem_* bus.
- Drives mem_ready/mem_rdata only for addresses it decodes; the top-level mux selects it on its own address hit.

Parameters:
- BASE_ADDR, 32'h1000_0000, address of DATA register; STATUS register is at BASE_ADDR+4.
- CLK_DIV, 868, clock cycles per UART bit; legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- mem_valid  in  1  picorv32 request valid; held until acknowledged
- mem_instr  in  1  instruction fetch flag; a hit with mem_instr=1 is acked with rdata 0
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data; bits [7:0] = character
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_ready  out  1  one-cycle acknowledge pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- hit  out  1  combinational: mem_valid && addr is DATA or STATUS (for bus mux)
- uart_tx  out  1  serial output, idle high
- tx_busy  out  1  FIFO non-empty or frame in progress

Behaviour:
- Reset (resetn=0 at a clk edge):
  - mem_ready=0, mem_rdata=0, uart_tx=1, tx_busy=0.
  - FIFO empty, baud counter=0, state=IDLE.
  - Reset mid-frame aborts the frame immediately: uart_tx=1 on the first edge with resetn=0.
- Decode: only addresses BASE_ADDR and BASE_ADDR+4 with mem_addr[1:0]=0 hit; all other addresses are ignored (no ready).
- Ack timing:
  - mem_ready is registered and asserts the cycle after an acceptable hit.
  - It is never high two consecutive cycles: no ack is issued while mem_ready=1, which guards against the still-held mem_valid.
- DATA write (mem_wstrb!=0):
  - If mem_wstrb[0]=1 and FIFO not full: push wdata[7:0] and ack.
  - If FIFO full: no ack; the CPU stalls until a pop frees a slot, then the push is accepted and acked.
  - If mem_wstrb[0]=0: ack and discard.
- DATA read: ack, rdata=0.
- STATUS read: ack, rdata = {16'b0, level[7:0], 6'b0, tx_busy, full}, where level = FIFO occupancy 0..2**FIFO_AW.
- STATUS write: ack, no effect.
- FIFO:
  - Simultaneous push and pop in the same cycle both occur; level is unchanged.
  - A push into a full FIFO never occurs, even if a pop happens that same cycle; the write acks one cycle later.
  - Pointers wrap modulo depth; level is FIFO_AW+1 bits.
- TX state machine (baud counter counts 0..CLK_DIV-1; each state lasts exactly CLK_DIV cycles):
  - IDLE: uart_tx=1. If FIFO non-empty, pop into shift register and go to START next cycle.
  - START: uart_tx=0 → DATA.
  - DATA: uart_tx = shift[0], LSB first; shift right each bit; after 8 bits → STOP.
  - STOP: uart_tx=1. On the last cycle, if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise → IDLE.
- Latency: an accepted write into an empty, idle block drives the start bit 2 cycles after the ack cycle.
- Frame length: 10*CLK_DIV cycles (11*CLK_DIV with parity).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP, driving even parity (XOR of the 8 data bits) for CLK_DIV cycles; frame = 11 bit times.
- Undefined: no PARITY state; 8N1 frame as above.

Test Plan (CLK_DIV=4, FIFO_AW=2):
- Reset check: resetn low 5 cycles mid-frame → uart_tx=1 next edge, mem_ready=0, STATUS read after release = 0x00000000.
- Single write: write 0x00000041, wstrb=4'b0001, to 0x1000_0000 → mem_ready single pulse 1 cycle later; uart_tx = 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles; tx_busy drops after stop.
- Back-to-back: write 'H','i' → two frames with no idle gap between stop bit and next start bit, 80 cycles total.
- Full stall: 5 writes while the first frame is still sending (FIFO holds 4) → 5th write withholds mem_ready until the first pop, then acks; all 5 chars appear in order.
- STATUS: 3 chars queued, TX active → read 0x1000_0004 returns 0x00000302 (or 0x00000202 if one char already popped; check exact cycle).
- Decode/strobes: access 0x1000_0008 → no mem_ready, hit=0; write wstrb=4'b0010 to DATA → acked, nothing transmitted; with UART_TX_PARITY_EN, 'A' gives parity bit 0 and 'C' gives 1.
